// File: rtl/rv32i_types.sv
//==============================================================================
// Module      : rv32i_types (package)
// Description : Shared RV32I core types. Holds the memory-port arbiter state
//               encoding, the latched memory command record and a small
//               saturating-increment helper used by the arbiter streak counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rv32i_types;

    // Memory-port arbiter FSM encoding (explicit 2-bit width).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // One complete command for the physical memory port.
    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic        write;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Idle command: every physical-port field low.
    localparam mem_cmd_t c_mem_cmd_idle = '0;

    // Increment that sticks at 'limit' instead of wrapping.
    function automatic logic [3:0] streak_inc(input logic [3:0] cur,
                                              input logic [3:0] limit);
        if (cur >= limit) begin
            return limit;
        end
        return cur + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Shares one physical memory port between the instruction-fetch
//               (i_*) and data (d_*) requesters. One requester is granted at a
//               time; its command is latched and driven on m_* until m_resp,
//               which is forwarded combinationally as a one-cycle x_resp with
//               x_rdata. Data has priority, but after MAX_D_STREAK consecutive
//               data grants made while a fetch waits, the fetch is granted.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_addr/i_read       - fetch request (held until i_resp)
//               i_rdata/i_resp      - fetch completion
//               d_addr/d_read/d_write/d_wmask/d_wdata - data request
//               d_rdata/d_resp      - data completion
//               m_addr/m_read/m_write/m_wmask/m_wdata - physical command
//               m_rdata/m_resp      - physical completion
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned MAX_D_STREAK = 4   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_addr,
    input  logic        i_read,
    output logic [31:0] i_rdata,
    output logic        i_resp,

    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,

    output logic [31:0] m_addr,
    output logic        m_read,
    output logic        m_write,
    output logic [3:0]  m_wmask,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_resp
);

    localparam logic [3:0] c_streak_max = 4'(MAX_D_STREAK);

    arb_state_t  state_q,  state_d;
    logic [3:0]  streak_q, streak_d;
    mem_cmd_t    cmd_q,    cmd_d;

    logic        w_d_pend;
    logic        w_i_starved;

    assign w_d_pend    = d_read | d_write;
    // The fetch has waited through the maximum data streak: it wins this time.
    assign w_i_starved = i_read && (streak_q >= c_streak_max);

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            cmd_q    <= c_mem_cmd_idle;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            cmd_q    <= cmd_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        cmd_d    = cmd_q;

        unique case (state_q)
            IDLE: begin
                if (w_d_pend && !w_i_starved) begin
                    state_d     = BUSY_D;
                    cmd_d.addr  = d_addr;
                    // read+write together is resolved as a write.
                    cmd_d.read  = d_read & ~d_write;
                    cmd_d.write = d_write;
                    cmd_d.wmask = d_wmask;
                    cmd_d.wdata = d_wdata;
                    // Only data grants that make a fetch wait count.
                    streak_d    = i_read ? streak_inc(streak_q, c_streak_max) : 4'd0;
                end else if (i_read) begin
                    state_d     = BUSY_I;
                    cmd_d.addr  = i_addr;
                    cmd_d.read  = 1'b1;
                    cmd_d.write = 1'b0;
                    cmd_d.wmask = '0;
                    cmd_d.wdata = '0;
                    streak_d    = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                // Requester inputs are deliberately ignored until completion.
                if (m_resp) begin
                    state_d = IDLE;
                    cmd_d   = c_mem_cmd_idle;
                end
            end

            default: begin
                state_d = IDLE;
                cmd_d   = c_mem_cmd_idle;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Output logic
    //--------------------------------------------------------------------------
    always_comb begin
        // The latched command is cleared whenever the FSM is idle, so the
        // physical port is quiet outside BUSY without extra gating.
        m_addr  = cmd_q.addr;
        m_read  = cmd_q.read;
        m_write = cmd_q.write;
        m_wmask = cmd_q.wmask;
        m_wdata = cmd_q.wdata;

        i_resp  = 1'b0;
        i_rdata = '0;
        d_resp  = 1'b0;
        d_rdata = '0;

        // m_resp is steered by the owning state only; in IDLE it is dropped.
        if (m_resp) begin
            if (state_q == BUSY_I) begin
                i_resp  = 1'b1;
                i_rdata = m_rdata;
            end else if (state_q == BUSY_D) begin
                d_resp  = 1'b1;
                d_rdata = m_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A per-cycle vector
//               table covers reset, fetch-only, simultaneous requests, idle
//               m_resp, hold-off and read+write; hand-written sequences cover
//               the starvation pattern and reset in the middle of a fetch.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_read;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic [31:0] d_addr;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic [31:0] m_addr;
    logic        m_read;
    logic        m_write;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_resp;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (i_addr),
        .i_read  (i_read),
        .i_rdata (i_rdata),
        .i_resp  (i_resp),
        .d_addr  (d_addr),
        .d_read  (d_read),
        .d_write (d_write),
        .d_wmask (d_wmask),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_resp  (d_resp),
        .m_addr  (m_addr),
        .m_read  (m_read),
        .m_write (m_write),
        .m_wmask (m_wmask),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_resp  (m_resp)
    );

    typedef struct packed {
        logic [31:0] m_addr;
        logic        m_read;
        logic        m_write;
        logic [3:0]  m_wmask;
        logic [31:0] m_wdata;
        logic        i_resp;
        logic [31:0] i_rdata;
        logic        d_resp;
        logic [31:0] d_rdata;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        i_read;
        logic [31:0] i_addr;
        logic        d_read;
        logic        d_write;
        logic [31:0] d_addr;
        logic [3:0]  d_wmask;
        logic [31:0] d_wdata;
        logic        m_resp;
        logic [31:0] m_rdata;
        out_t        exp;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    function automatic out_t ex(input logic [31:0] ma, input logic mr, input logic mw,
                                input logic [3:0] mm, input logic [31:0] md,
                                input logic ir, input logic [31:0] ird,
                                input logic dr, input logic [31:0] drd);
        out_t o;
        o.m_addr = ma; o.m_read = mr; o.m_write = mw; o.m_wmask = mm; o.m_wdata = md;
        o.i_resp = ir; o.i_rdata = ird; o.d_resp = dr; o.d_rdata = drd;
        return o;
    endfunction

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [3:0] wm, input logic [31:0] wd,
                                input logic mr, input logic [31:0] md, input out_t e);
        vec_t v;
        v.rst = r; v.i_read = ir; v.i_addr = ia; v.d_read = dr; v.d_write = dw;
        v.d_addr = da; v.d_wmask = wm; v.d_wdata = wd; v.m_resp = mr; v.m_rdata = md;
        v.exp = e;
        return v;
    endfunction

    function automatic out_t sample();
        return ex(m_addr, m_read, m_write, m_wmask, m_wdata, i_resp, i_rdata, d_resp, d_rdata);
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic drive_idle();
        rst = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wmask = '0; d_wdata = '0; m_resp = 1'b0; m_rdata = '0;
    endtask

    initial begin
        out_t z;
        logic got [6];
        logic exp_seq [6];
        int   grants;
        int   cyc;

        z = '0;
        // Columns: rst, i_read, i_addr, d_read, d_write, d_addr, d_wmask, d_wdata, m_resp, m_rdata, expected
        // Reset state
        tbl[0]  = mk(1, 0, 32'h0,   0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        z);
        // Fetch only: memory answers in the third BUSY cycle
        tbl[1]  = mk(0, 1, 32'h60,  0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        z);
        tbl[2]  = mk(0, 1, 32'h60,  0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,
                     ex(32'h60, 1, 0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0));
        tbl[3]  = mk(0, 1, 32'h60,  0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,
                     ex(32'h60, 1, 0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0));
        tbl[4]  = mk(0, 1, 32'h60,  0, 0, 32'h0,   4'h0, 32'h0,        1, 32'hDEADBEEF,
                     ex(32'h60, 1, 0, 4'h0, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0));
        // m_resp while IDLE is dropped
        tbl[5]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   4'h0, 32'h0,        1, 32'h55,       z);
        // Simultaneous fetch and store: store first
        tbl[6]  = mk(0, 1, 32'h200, 0, 1, 32'h100, 4'hF, 32'h12345678, 0, 32'h0,        z);
        tbl[7]  = mk(0, 1, 32'h200, 0, 1, 32'h100, 4'hF, 32'h12345678, 1, 32'hAAAA0000,
                     ex(32'h100, 0, 1, 4'hF, 32'h12345678, 0, 32'h0, 1, 32'hAAAA0000));
        tbl[8]  = mk(0, 1, 32'h200, 0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        z);
        tbl[9]  = mk(0, 1, 32'h200, 0, 0, 32'h0,   4'h0, 32'h0,        1, 32'h0BADF00D,
                     ex(32'h200, 1, 0, 4'h0, 32'h0, 1, 32'h0BADF00D, 0, 32'h0));
        tbl[10] = mk(0, 0, 32'h0,   0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        z);
        // read+write together resolves to a write; inputs changed while busy are ignored
        tbl[11] = mk(0, 0, 32'h0,   1, 1, 32'h300, 4'h3, 32'hCAFE,     0, 32'h0,        z);
        tbl[12] = mk(0, 0, 32'h0,   1, 1, 32'h999, 4'hC, 32'h1111,     0, 32'h0,
                     ex(32'h300, 0, 1, 4'h3, 32'hCAFE, 0, 32'h0, 0, 32'h0));
        tbl[13] = mk(0, 0, 32'h0,   1, 1, 32'h999, 4'hC, 32'h1111,     1, 32'h77,
                     ex(32'h300, 0, 1, 4'h3, 32'hCAFE, 0, 32'h0, 1, 32'h77));
        tbl[14] = mk(0, 0, 32'h0,   0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        z);

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            rst = tbl[k].rst;     i_read = tbl[k].i_read; i_addr = tbl[k].i_addr;
            d_read = tbl[k].d_read; d_write = tbl[k].d_write; d_addr = tbl[k].d_addr;
            d_wmask = tbl[k].d_wmask; d_wdata = tbl[k].d_wdata;
            m_resp = tbl[k].m_resp; m_rdata = tbl[k].m_rdata;
            #1;
            check_out($sformatf("vec%0d", k), sample(), tbl[k].exp);
        end

        // Starvation: store and fetch held continuously, memory answers at once.
        exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
        exp_seq[4] = 1; exp_seq[5] = 0;
        grants = 0;
        cyc = 0;
        while (grants < 6 && cyc < 60) begin
            @(negedge clk);
            drive_idle();
            i_read = 1'b1; i_addr = 32'h500;
            d_write = 1'b1; d_addr = 32'h400; d_wmask = 4'hF; d_wdata = 32'(cyc);
            m_resp = m_read | m_write;
            #1;
            if (i_resp && d_resp) begin
                checks++;
                $display("FAIL dual_resp: i_resp=%b d_resp=%b required one-hot", i_resp, d_resp);
            end
            if (i_resp) begin
                got[grants] = 1'b1;
                grants++;
            end else if (d_resp) begin
                got[grants] = 1'b0;
                grants++;
            end
            cyc++;
        end
        // Requests drop after the final response; that edge returns the FSM to IDLE.
        i_read = 1'b0; d_write = 1'b0;
        checks++;
        if (grants == 6) passed++;
        else $display("FAIL starve_timeout: grants %0d required 6", grants);
        for (int g = 0; g < grants; g++)
            check_bit($sformatf("starve_grant%0d_is_fetch", g), got[g], exp_seq[g]);

        // Reset in the middle of a fetch.
        @(negedge clk);
        drive_idle();
        i_read = 1'b1; i_addr = 32'h700;
        @(negedge clk);
        #1;
        check_out("rst_pre_busy_i", sample(),
                  ex(32'h700, 1, 0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_read = 1'b0;
        #1;
        check_out("rst_outputs_zero", sample(), z);
        @(negedge clk);
        m_resp = 1'b1; m_rdata = 32'hFEEDFACE;
        #1;
        check_out("rst_late_resp_ignored", sample(), z);
        @(negedge clk);
        drive_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
